// File: rtl/gf163_pkg.sv
// Shared constants and types for the GF(2^163) digit-serial operand feeder.
package gf163_pkg;

    localparam int M     = 163;          // field degree / operand width
    localparam int D     = 8;            // digit width
    localparam int NDIG  = 21;           // digits per operand, ceil(M/D)
    localparam int PADW  = 5;            // zero pad bits, NDIG*D-M
    localparam int W     = NDIG * D;     // framed operand width
    localparam int CNT_W = 5;            // enough to hold NDIG-1

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(NDIG - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef logic [D-1:0] digit_t;

    // Zero-extend an operand to the full digit frame; pad bits never come from outside.
    function automatic logic [W-1:0] frame(input logic [M-1:0] x);
        return {{PADW{1'b0}}, x};
    endfunction

endpackage

// File: rtl/digit_shreg.sv
// One framed operand register: parallel load, shift left by one digit,
// most-significant digit presented as the output tap.
module digit_shreg
    import gf163_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         ld,
    input  logic         shift,
    input  logic [W-1:0] din,
    output digit_t       msd
);

    logic [W-1:0] sr;

    // Load has priority; loading zeros is how the feeder blanks its outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr <= '0;
        end else if (ld) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[W-D-1:0], {D{1'b0}}};
        end
    end

    assign msd = sr[W-1 -: D];

endmodule

// File: rtl/gf163_digit_feeder.sv
// Streams (a, b, g) operand sets into the 8-digit systolic multiplier,
// most-significant digit first, with a one-set pending buffer for gapless
// back-to-back operation.
module gf163_digit_feeder
    import gf163_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic [M-1:0] g,
    output digit_t       a_in,
    output digit_t       b_in,
    output digit_t       g_in,
    output logic         ctr,
    output logic         busy
);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              pend_vld;
    logic [M-1:0]      pend_a, pend_b, pend_g;

    logic              xfer;
    logic              sr_ld, sr_shift, cnt_ld, pend_ld, pend_clr, ctr_nx;
    logic [W-1:0]      ld_a, ld_b, ld_g;

    assign in_ready = !pend_vld;
    assign xfer     = in_valid & in_ready;
    assign busy     = (state == STREAM) | pend_vld;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and datapath controls; the last-digit cycle chooses between
    // pending reload, direct bypass of a fresh set, or blanking to idle.
    always_comb begin
        state_nx = state;
        sr_ld    = 1'b0;
        sr_shift = 1'b0;
        cnt_ld   = 1'b0;
        pend_ld  = 1'b0;
        pend_clr = 1'b0;
        ctr_nx   = 1'b0;
        ld_a     = frame(a);
        ld_b     = frame(b);
        ld_g     = frame(g);
        case (state)
            IDLE: begin
                if (xfer) begin
                    sr_ld    = 1'b1;
                    cnt_ld   = 1'b1;
                    ctr_nx   = 1'b1;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                if (cnt != '0) begin
                    sr_shift = 1'b1;
                    pend_ld  = xfer;
                end else if (pend_vld) begin
                    sr_ld    = 1'b1;
                    cnt_ld   = 1'b1;
                    ctr_nx   = 1'b1;
                    pend_clr = 1'b1;
                    ld_a     = frame(pend_a);
                    ld_b     = frame(pend_b);
                    ld_g     = frame(pend_g);
                end else if (xfer) begin
                    sr_ld    = 1'b1;
                    cnt_ld   = 1'b1;
                    ctr_nx   = 1'b1;
                end else begin
                    sr_ld    = 1'b1;
                    ld_a     = '0;
                    ld_b     = '0;
                    ld_g     = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Digit down-counter: restarts at the top digit on every load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         cnt <= '0;
        else if (cnt_ld)   cnt <= CNT_TOP;
        else if (sr_shift) cnt <= cnt - 1'b1;
    end

    // Pending buffer: filled while streaming, drained on the last digit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_vld <= 1'b0;
            pend_a   <= '0;
            pend_b   <= '0;
            pend_g   <= '0;
        end else if (pend_ld) begin
            pend_vld <= 1'b1;
            pend_a   <= a;
            pend_b   <= b;
            pend_g   <= g;
        end else if (pend_clr) begin
            pend_vld <= 1'b0;
        end
    end

    // Start-of-operation marker, aligned with the first digit of each set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ctr <= 1'b0;
        else       ctr <= ctr_nx;
    end

    digit_shreg u_sr_a (
        .clk   (clk),
        .rstn  (rstn),
        .ld    (sr_ld),
        .shift (sr_shift),
        .din   (ld_a),
        .msd   (a_in)
    );

    digit_shreg u_sr_b (
        .clk   (clk),
        .rstn  (rstn),
        .ld    (sr_ld),
        .shift (sr_shift),
        .din   (ld_b),
        .msd   (b_in)
    );

    digit_shreg u_sr_g (
        .clk   (clk),
        .rstn  (rstn),
        .ld    (sr_ld),
        .shift (sr_shift),
        .din   (ld_g),
        .msd   (g_in)
    );

endmodule

// File: tb/tb_gf163_digit_feeder.sv
// Directed bench for gf163_digit_feeder: hand-checked vectors plus a
// monitor that compares every digit cycle against the framed operands.
module tb_gf163_digit_feeder;
    import gf163_pkg::*;

    typedef struct {
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [M-1:0] g;
    } set_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [M-1:0] a = '0, b = '0, g = '0;
    digit_t       a_in, b_in, g_in;
    logic         ctr, busy;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    set_t q[$];
    set_t cur;
    logic mon_active = 1'b0;
    int   mon_k = 0;
    logic have_prev = 1'b0;
    int   prev_ctr_cyc = 0;
    int   last_gap = 0;
    int   n_ctr = 0;

    gf163_digit_feeder dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .g        (g),
        .a_in     (a_in),
        .b_in     (b_in),
        .g_in     (g_in),
        .ctr      (ctr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic digit_t dig(input logic [M-1:0] x, input int k);
        logic [W-1:0] e;
        e = {{PADW{1'b0}}, x};
        return e[8*k +: 8];
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            mon_active = 1'b0;
            have_prev  = 1'b0;
            chk("rst_outs", {7'd0, ctr, a_in, b_in, g_in}, 32'd0);
        end else begin
            if (ctr) begin
                n_ctr++;
                if (have_prev) last_gap = cyc - prev_ctr_cyc;
                have_prev    = 1'b1;
                prev_ctr_cyc = cyc;
                if (q.size() == 0) begin
                    chk("unexpected_ctr", 32'd1, 32'd0);
                    mon_active = 1'b0;
                end else begin
                    cur = q.pop_front();
                    mon_active = 1'b1;
                    mon_k = NDIG - 1;
                end
            end
            if (mon_active) begin
                chk("digit", {7'd0, ctr, a_in, b_in, g_in},
                    {7'd0, (mon_k == NDIG - 1), dig(cur.a, mon_k), dig(cur.b, mon_k), dig(cur.g, mon_k)});
                if (mon_k == 0) mon_active = 1'b0;
                else            mon_k--;
            end else begin
                chk("idle_outs", {7'd0, ctr, a_in, b_in, g_in}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a set until accepted; returns with in_valid still high, one step
    // after the accepting edge. stalls = cycles spent with in_ready low.
    task automatic send(input set_t s, output int stalls);
        logic ok;
        a = s.a; b = s.b; g = s.g;
        in_valid = 1'b1;
        stalls = 0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            if (ok) q.push_back(s);
            else    stalls++;
            #1;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((busy || mon_active || q.size() != 0) && i < 500) begin
            tick();
            i++;
        end
        chk("drain_timeout", {31'd0, (i >= 500)}, 32'd0);
    endtask

    set_t s1, s2, s3;
    int   st;
    int   ctr_before;

    initial begin
        s1.a = 163'd1;
        s1.b = 163'd1 << 162;
        s1.g = 163'hC9;
        s2.a = 163'h7_DEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        s2.b = 163'h5_5555_5555_5555_5555_5555_5555_5555_5555_5555_5555;
        s2.g = {163{1'b1}};
        s3.a = 163'h2_A5A5_0000_1111_2222_3333_4444_5555_6666_7777_8888;
        s3.b = 163'h0_0000_0000_0000_0000_0000_0000_0000_0000_0000_00FF;
        s3.g = (163'd1 << 163'd7) | (163'd1 << 163'd6) | (163'd1 << 163'd3) | 163'd1;

        // Reset and idle
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ctr", {31'd0, ctr}, 32'd0);
        repeat (3) tick();
        rstn = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (30) begin
            tick();
            chk("idle_ready_busy", {30'd0, in_ready, busy}, 32'b10);
        end

        // Single set with hand-computed first and last digits
        send(s1, st);
        in_valid = 1'b0;
        chk("single_first", {7'd0, ctr, a_in, b_in, g_in}, {7'd0, 1'b1, 8'h00, 8'h04, 8'h00});
        chk("single_busy", {31'd0, busy}, 32'd1);
        repeat (20) tick();
        chk("single_last", {7'd0, ctr, a_in, b_in, g_in}, {7'd0, 1'b0, 8'h01, 8'h00, 8'hC9});
        tick();
        chk("single_after", {7'd0, ctr, a_in, b_in, g_in, 1'b0}, 33'd0);
        chk("single_idle_busy", {31'd0, busy}, 32'd0);
        drain();

        // Back-to-back: second set offered mid-stream goes to pending
        send(s1, st);
        in_valid = 1'b0;
        repeat (5) tick();
        send(s2, st);
        in_valid = 1'b0;
        chk("b2b_pend_stall", st, 0);
        chk("b2b_ready_low", {31'd0, in_ready}, 32'd0);
        ctr_before = n_ctr;
        for (int i = 0; i < 40 && n_ctr == ctr_before; i++) begin
            tick();
            if (n_ctr == ctr_before && !ctr)
                chk("b2b_ready_hold", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk); #1;
        chk("b2b_gap", last_gap, NDIG);
        chk("b2b_ready_back", {31'd0, in_ready}, 32'd1);
        drain();

        // Three sets, in_valid held high: third stalls until pending drains
        send(s1, st);
        send(s2, st);
        chk("three_second_stall", st, 0);
        send(s3, st);
        in_valid = 1'b0;
        chk("three_third_stall", st, 20);
        drain();
        chk("three_gap", last_gap, NDIG);

        // Bypass: offer exactly on the last-digit cycle with pending empty
        send(s2, st);
        in_valid = 1'b0;
        repeat (20) tick();
        chk("byp_lastdig", {7'd0, ctr, a_in, b_in, g_in},
            {7'd0, 1'b0, dig(s2.a, 0), dig(s2.b, 0), dig(s2.g, 0)});
        send(s3, st);
        in_valid = 1'b0;
        chk("byp_stall", st, 0);
        chk("byp_ctr", {7'd0, ctr, a_in, b_in, g_in},
            {7'd0, 1'b1, dig(s3.a, 20), dig(s3.b, 20), dig(s3.g, 20)});
        @(negedge clk); #1;
        chk("byp_gap", last_gap, NDIG);
        drain();

        // Reset mid-stream with pending full
        send(s2, st);
        in_valid = 1'b0;
        repeat (3) tick();
        send(s3, st);
        in_valid = 1'b0;
        repeat (6) tick();
        chk("rst_pre_busy", {30'd0, busy, in_ready}, 32'b10);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_mid_outs", {7'd0, ctr, a_in, b_in, g_in}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (2) tick();
        rstn = 1'b1;
        #1;
        chk("rst_rel_ready", {30'd0, in_ready, busy}, 32'b10);
        repeat (30) begin
            tick();
            chk("rst_rel_idle", {7'd0, ctr, a_in, b_in, g_in}, 32'd0);
        end
        chk("rst_rel_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
